// File: rtl/uart_rx_sampler_if.sv
// Serial receive bundle: the line in, the received byte and its status strobes out.
interface uart_rx_sampler_if;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       error;
   logic       RX_active;

   modport master (output rx, input data_out, valid, error, RX_active);
   modport slave  (input rx, output data_out, valid, error, RX_active);
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with 2-flop synchroniser, mid-bit sampling and framing check.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_sampler #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 8
) (
   input logic               clk,
   input logic               reset,
   uart_rx_sampler_if.slave  bus
);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             rx_meta;
   logic             rx_s;
   logic             frame_ok;

   // Synchroniser resets to idle-high so releasing reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make both flops sample the old value,
         // giving a true two-stage shift instead of a single wire.
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_err;
   always_comb frame_ok = rx_s && !par_err;
`else
   always_comb frame_ok = rx_s;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         bus.data_out  <= '0;
         bus.valid     <= 1'b0;
         bus.error     <= 1'b0;
         bus.RX_active <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err       <= 1'b0;
`endif
      end else begin
         bus.valid <= 1'b0;
         bus.error <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state         <= START;
                  cnt           <= '0;
                  bus.RX_active <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state         <= IDLE;
                     bus.RX_active <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  shift_reg[bit_idx] <= rx_s;
                  cnt                <= '0;
                  bit_idx            <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == FULL_M1) begin
                  par_err <= ^{shift_reg, rx_s};
                  cnt     <= '0;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt == FULL_M1) begin
                  cnt           <= '0;
                  bus.data_out  <= shift_reg;
                  bus.RX_active <= 1'b0;
                  bus.valid     <= frame_ok;
                  bus.error     <= !frame_ok;
                  // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                  state         <= rx_s ? IDLE : BREAK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: latency, framing, break, glitch, back-to-back, reset.
module tb_uart_rx_sampler;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
   localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   uart_rx_sampler_if bus ();

   uart_rx_sampler #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #2 clk = ~clk;

   // Passive monitor; tasks work from snapshots of these counters.
   int         pos_cnt = 0;
   int         valid_cnt = 0;
   int         error_cnt = 0;
   int         both_cnt = 0;
   int         active_cnt = 0;
   int         last_valid_pos = 0;
   int         last_error_pos = 0;
   logic [7:0] vlog[$];

   always @(posedge clk) pos_cnt <= pos_cnt + 1;

   always @(negedge clk) begin
      if (bus.valid) begin
         valid_cnt++;
         last_valid_pos = pos_cnt;
         vlog.push_back(bus.data_out);
      end
      if (bus.error) begin
         error_cnt++;
         last_error_pos = pos_cnt;
      end
      if (bus.valid && bus.error) both_cnt++;
      if (bus.RX_active) active_cnt++;
   end

   task automatic drive_bit(input logic b);
      bus.rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Called on a negedge; returns the posedge count just before edge 0.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input logic par_flip, output int start_pos);
      start_pos = pos_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d ^ par_flip);
`endif
      drive_bit(stop_bit);
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      bus.rx = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%0h want=00", bus.data_out); end
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", bus.valid); end
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b want=0", bus.error); end
      checks++; if (bus.RX_active !== 1'b0) begin errors++; $display("FAIL reset_rx_active got=%0b want=0", bus.RX_active); end
      reset = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (bus.RX_active !== 1'b0) begin errors++; $display("FAIL release_no_start got=%0b want=0", bus.RX_active); end
   endtask

   task automatic test_good_frame();
      int v0, e0, sp, lat;
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'hAC, 1'b1, 1'b0, sp);
      idle(10);
      lat = last_valid_pos - sp - 1;
      checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL ac_valid_count got=%0d want=1", valid_cnt - v0); end
      checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL ac_latency got=%0d want=%0d", lat, LAT); end
      checks++; if (bus.data_out !== 8'b1010_1100) begin errors++; $display("FAIL ac_data got=%0h want=ac", bus.data_out); end
      checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL ac_error_count got=%0d want=0", error_cnt - e0); end
   endtask

   task automatic test_break();
      int v0, e0, a0, sp;
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'h55, 1'b0, 1'b0, sp);
      a0 = active_cnt;
      bus.rx = 1'b0;
      repeat (40 * CPB) @(negedge clk);
      checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL break_error_count got=%0d want=1", error_cnt - e0); end
      checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL break_valid_count got=%0d want=0", valid_cnt - v0); end
      checks++; if (bus.data_out !== 8'h55) begin errors++; $display("FAIL break_data got=%0h want=55", bus.data_out); end
      checks++; if (active_cnt - a0 !== 0) begin errors++; $display("FAIL break_rx_active cycles=%0d want=0", active_cnt - a0); end
      idle(CPB);
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'h3C, 1'b1, 1'b0, sp);
      idle(10);
      checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL after_break_valid got=%0d want=1", valid_cnt - v0); end
      checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL after_break_data got=%0h want=3c", bus.data_out); end
      checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL after_break_error got=%0d want=0", error_cnt - e0); end
   endtask

   task automatic test_glitch();
      int v0, e0, a0, sp;
      v0 = valid_cnt; e0 = error_cnt; a0 = active_cnt;
      bus.rx = 1'b0;
      repeat (4) @(negedge clk);
      idle(3 * CPB);
      checks++; if (active_cnt - a0 == 0) begin errors++; $display("FAIL glitch_rx_active_pulse cycles=%0d want>0", active_cnt - a0); end
      checks++; if (bus.RX_active !== 1'b0) begin errors++; $display("FAIL glitch_rx_active_end got=%0b want=0", bus.RX_active); end
      checks++; if (valid_cnt - v0 + error_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_strobes got=%0d want=0", valid_cnt - v0 + error_cnt - e0); end
      send_frame(8'hFF, 1'b1, 1'b0, sp);
      idle(10);
      checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL ff_valid got=%0d want=1", valid_cnt - v0); end
      checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("FAIL ff_data got=%0h want=ff", bus.data_out); end
   endtask

   task automatic test_back_to_back();
      int v0, e0, i0, sp;
      v0 = valid_cnt; e0 = error_cnt; i0 = vlog.size();
      send_frame(8'h01, 1'b1, 1'b0, sp);
      send_frame(8'h80, 1'b1, 1'b0, sp);
      idle(10);
      checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got=%0d want=2", valid_cnt - v0); end
      checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_error_count got=%0d want=0", error_cnt - e0); end
      if (vlog.size() >= i0 + 2) begin
         checks++; if (vlog[i0] !== 8'h01) begin errors++; $display("FAIL b2b_first got=%0h want=01", vlog[i0]); end
         checks++; if (vlog[i0+1] !== 8'h80) begin errors++; $display("FAIL b2b_second got=%0h want=80", vlog[i0+1]); end
      end else begin
         checks++; errors++; $display("FAIL b2b_log entries=%0d want=2", vlog.size() - i0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int v0, e0, sp;
      logic [7:0] d;
      d = 8'hA5;
      v0 = valid_cnt; e0 = error_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      bus.rx = d[4];
      repeat (CPB / 2) @(negedge clk);
      checks++; if (bus.RX_active !== 1'b1) begin errors++; $display("FAIL midframe_active got=%0b want=1", bus.RX_active); end
      reset  = 1'b0;
      bus.rx = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if ({bus.data_out, bus.valid, bus.error, bus.RX_active} !== 11'h000) begin
         errors++; $display("FAIL midreset_outputs got=%0h/%0b%0b%0b want=0", bus.data_out, bus.valid, bus.error, bus.RX_active);
      end
      repeat (5) @(negedge clk);
      reset = 1'b1;
      idle(2 * CPB);
      checks++; if (valid_cnt - v0 + error_cnt - e0 !== 0) begin errors++; $display("FAIL a5_no_strobe got=%0d want=0", valid_cnt - v0 + error_cnt - e0); end
      send_frame(8'h5A, 1'b1, 1'b0, sp);
      idle(10);
      checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL 5a_valid got=%0d want=1", valid_cnt - v0); end
      checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL 5a_data got=%0h want=5a", bus.data_out); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0, e0, sp, lat;
      idle(2 * CPB);
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'hAC, 1'b1, 1'b1, sp);
      idle(10);
      lat = last_error_pos - sp - 1;
      checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL par_error_count got=%0d want=1", error_cnt - e0); end
      checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL par_valid_count got=%0d want=0", valid_cnt - v0); end
      checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL par_latency got=%0d want=%0d", lat, LAT); end
      checks++; if (bus.data_out !== 8'hAC) begin errors++; $display("FAIL par_data got=%0h want=ac", bus.data_out); end
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'hAC, 1'b1, 1'b0, sp);
      idle(10);
      checks++; if (valid_cnt - v0 !== 1 || error_cnt - e0 !== 0) begin errors++; $display("FAIL par_good got=%0d/%0d want=1/0", valid_cnt - v0, error_cnt - e0); end
   endtask
`endif

   initial begin
      bus.rx = 1'b1;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_break();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_error_overlap cycles=%0d want=0", both_cnt); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Standalone 8-bit UART receiver: the receive end of the team's 8N1 serial link.
- Takes the asynchronous serial line `rx` and synchronises it.
- Qualifies the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the byte with a one-cycle `valid` or `error` strobe.
- Loops back against the existing UART transmitter (`data_in`/`transmit`/`TX_active`) in the top-level bench.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit; must be even and >= 4.
- CNT_W, 8, bit-counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high; LSB first.
- data_out  output  8  last received byte.
- valid  output  1  one-cycle strobe: good frame, `data_out` updated.
- error  output  1  one-cycle strobe: framing error (or parity error when enabled).
- RX_active  output  1  high while a frame is being received.

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE; all counters 0; shift register 0.
  - `data_out`=0, `valid`=0, `error`=0, `RX_active`=0.
  - Both synchroniser flops=1, so no false start on release.
- Synchroniser: 2 flops. The FSM sees only `rx_s`.
- IDLE:
  - `rx_s`=0 -> START, cnt=0.
- START:
  - cnt increments each clock.
  - At cnt==CLKS_PER_BIT/2-1:
    - `rx_s`=0 -> DATA, cnt=0, bit_idx=0.
    - `rx_s`=1 -> IDLE (glitch rejected; no strobe).
- DATA:
  - At cnt==CLKS_PER_BIT-1: shift `rx_s` into bit[bit_idx] (LSB first), cnt=0.
  - After bit_idx 7 -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample `rx_s`:
  - 1 -> `data_out`<=shift reg, `valid`<=1 for one clock, -> IDLE.
  - 0 -> `data_out`<=shift reg, `error`<=1 for one clock, `valid` stays 0, -> BREAK.
- BREAK:
  - Wait for `rx_s`=1, then IDLE.
  - A line held low produces exactly one `error`.
- Returning to IDLE at mid-stop-bit allows a back-to-back start bit with no extra idle time.
- `RX_active` = 1 in START, DATA, STOP (and PARITY); 0 in IDLE and BREAK.
  - Registered; rises the clock the FSM enters START.
- Latency: `rx` falling edge just before rising edge 0 -> `valid`/`error` high in the cycle after edge 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (154 for the default).
- `valid` and `error` are never high together.
- `data_out` holds its value between strobes.
- Reset mid-frame: abort immediately, no strobe; reception restarts on the next falling edge after release.

Optional Feature:
- Macro `UART_RX_PARITY_EN`.
- Defined:
  - PARITY state between DATA and STOP, one bit period long, sampled at cnt==CLKS_PER_BIT-1.
  - Even parity: the XOR of 8 data bits and the parity bit must be 0.
  - Mismatch: at stop sample, `error`=1 and `valid`=0 even if the stop bit is good. `data_out` still updated.
  - Good stop bit after a parity error -> IDLE, not BREAK.
  - Latency grows by CLKS_PER_BIT (170 for the default).
- Undefined: 8N1 only; no PARITY state.

Test Plan:
- Reset, then drive frame 0xAC (bits 0,0,1,1,0,1,0,1 after start), CLKS_PER_BIT=16, clk period 4 -> `valid`=1 for one cycle 154±1 clocks after start edge; `data_out`=8'b10101100; `error`=0.
- Frame 0x55 with stop bit driven 0, then `rx` held low 40 bit times -> `error`=1 exactly once; `data_out`=0x55; `valid` never asserts; `RX_active`=0 during break; next good frame 0x3C -> `valid`, `data_out`=0x3C.
- 4-clock low glitch on idle `rx` -> `RX_active` pulses and returns to 0; no `valid`/`error`; a following frame 0xFF is received correctly.
- Frames 0x01 then 0x80 back-to-back (one stop bit, no idle gap) -> two `valid` strobes; `data_out`=0x01 then 0x80.
- Assert reset at bit 4 of frame 0xA5, release after 10 clocks, then send 0x5A -> no strobe for 0xA5; all outputs 0 during reset; `valid` with `data_out`=0x5A.
- With `UART_RX_PARITY_EN`: frame 0xAC with parity 0 -> `valid`; same frame with parity 1 -> `error`, `data_out`=0xAC, `valid` at 170±1 clocks absent.
